ir_rgb_command_unit: RTL and testbench
======================================

# ir_rgb_command_unit

Consumes decoded 32-bit NEC frames from the infrared decoder (`code` + one-cycle `new_code` strobe) and turns them into three 8-bit colour levels for the per-channel PWM generators. Validates address and command complement, maps command bytes to saturating coarse/fine steps per channel, and optionally fades the driven levels toward their targets. Sits between the IR decoder and the three PWM instances in the top level.

## Interface
- `ADDRESS`, 16'h57E3, required value of `code_in[31:16]`
- `RESET_LEVEL`, 8'd1, reset value of all targets and levels
- `COARSE_STEP`, 8'd5, coarse step size
- `RAMP_DIV`, 100_000, clock cycles per fade step (IR_FADE_EN only), ≥2
- `clk_in` in 1 system clock (100 MHz)
- `rst_in` in 1 reset; asynchronous, active-high
- `code_in` in 32 decoded NEC frame; sampled only when `new_code_in`=1
- `new_code_in` in 1 one-cycle strobe, frame valid
- `red_out`, `green_out`, `blue_out` out 8 each, levels to PWM
- `cmd_ok_out` out 1 one-cycle pulse, command applied
- `err_out` out 2 one-cycle pulse code: 00 none, 01 address mismatch, 10 complement mismatch, 11 unknown command
- `busy_out` out 1 high while any level ≠ its target

## Operation
- Field split: address `code_in[31:16]`, command `code_in[15:8]`, complement `code_in[7:0]`.
- Stage 1 (capture/decode): on `new_code_in`, register frame, check address, then complement (`cmd == ~cmpl`), then command lookup. Error priority: address > complement > unknown.
- Command map: 0x1E R+COARSE, 0x1F R+1, 0x2C R−COARSE, 0x2D R−1, 0x46 G+COARSE, 0x47 G+1, 0x32 G−COARSE, 0x33 G−1, 0x86 B+COARSE, 0x87 B+1, 0xAA B−COARSE, 0xAB B−1, 0x0C all targets to 0, 0x0D all targets to 255.
- Stage 2 (apply): read-modify-write one target. Arithmetic in 9 bits; add saturates at 255, subtract saturates at 0 (e.g. 3−5 → 0, 253+5 → 255). Saturated command still counts as applied (`cmd_ok_out`=1).
- Errored frames: no target change, `err_out` pulses code, `cmd_ok_out`=0.
- Back-to-back strobes on consecutive cycles: every frame is processed in order; no drops, no stall.
- Without fade: levels equal targets.

## Timing
- Reset (async assert, anywhere incl. mid-fade/mid-pipeline): targets and levels = RESET_LEVEL, pipeline valids cleared, ramp counter 0, `cmd_ok_out`=0, `err_out`=0, `busy_out`=0.
- Strobe at cycle N → decode registered N+1 → target updated, `cmd_ok_out`/`err_out` pulse visible at N+2 (1 cycle wide).
- No fade: outputs change at N+2, `busy_out` constant 0.
- Fade: ramp counter free-runs 0..RAMP_DIV−1; on wrap, each level differing from target moves 1 toward it (channels independent). `busy_out` combinationally = any mismatch. Target change mid-fade retargets without resetting counter.

## Configuration
- `IR_FADE_EN` defined: fade engine, ramp counter and `busy_out` logic compiled in; levels step ±1 per RAMP_DIV cycles.
- Not defined: levels are targets directly; `busy_out` tied 0; `RAMP_DIV` unused.

## Test plan
- Reset with no frames → all outputs 1, `cmd_ok_out`=0, `err_out`=0 after release.
- Frame 32'h57E31EE1 (no fade) → `red_out` 1→6 two cycles after strobe, `cmd_ok_out` pulse 1 cycle.
- Red at 3, frame 32'h57E32CD3 → red 0; green at 253, frame 32'h57E346B9 → green 255; both `cmd_ok_out`.
- Frames 32'h12341EE1, 32'h57E31E00, 32'h57E35AA5 → `err_out` 01, 10, 11 respectively; levels unchanged.
- Three strobes on consecutive cycles (R+1, R+1, R−COARSE from red 10) → red 10→11→12→7 on consecutive cycles.
- IR_FADE_EN, RAMP_DIV=4: frame 0x0D from reset → each level +1 every 4 cycles, `busy_out` high until all 255; async reset mid-ramp → all 1, `busy_out` 0 immediately.

Source files
------------

// File: rtl/ir_rgb_command_unit.sv
// IR NEC frame -> three 8-bit colour levels: decode/validate, saturating target update,
// optional fade engine compiled in with IR_FADE_EN.
module ir_rgb_command_unit #(
  parameter logic [15:0] ADDRESS     = 16'h57E3,
  parameter logic [7:0]  RESET_LEVEL = 8'd1,
  parameter logic [7:0]  COARSE_STEP = 8'd5,
  parameter int unsigned RAMP_DIV    = 100_000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] code_in,
  input  logic        new_code_in,
  output logic [7:0]  red_out,
  output logic [7:0]  green_out,
  output logic [7:0]  blue_out,
  output logic        cmd_ok_out,
  output logic [1:0]  err_out,
  output logic        busy_out
);

  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_CLR, OP_SET} op_e;

  typedef struct packed {
    logic [1:0] err;
    logic [1:0] ch;
    op_e        op;
    logic [7:0] amt;
  } dec_t;

  dec_t            dec_d, dec_q;
  logic            s1_vld;
  logic [2:0][7:0] tgt, tgt_nxt, stepped, lvl;

  // Stage 1: field split, error priority address > complement > unknown.
  always_comb begin
    logic [1:0] ch;
    op_e        op;
    logic       fine, known;
    ch    = 2'd0;
    op    = OP_ADD;
    fine  = 1'b0;
    known = 1'b1;
    case (code_in[15:8])
      8'h1E: ch = 2'd0;
      8'h1F: begin ch = 2'd0; fine = 1'b1; end
      8'h2C: begin ch = 2'd0; op = OP_SUB; end
      8'h2D: begin ch = 2'd0; op = OP_SUB; fine = 1'b1; end
      8'h46: ch = 2'd1;
      8'h47: begin ch = 2'd1; fine = 1'b1; end
      8'h32: begin ch = 2'd1; op = OP_SUB; end
      8'h33: begin ch = 2'd1; op = OP_SUB; fine = 1'b1; end
      8'h86: ch = 2'd2;
      8'h87: begin ch = 2'd2; fine = 1'b1; end
      8'hAA: begin ch = 2'd2; op = OP_SUB; end
      8'hAB: begin ch = 2'd2; op = OP_SUB; fine = 1'b1; end
      8'h0C: op = OP_CLR;
      8'h0D: op = OP_SET;
      default: known = 1'b0;
    endcase
    dec_d.ch  = ch;
    dec_d.op  = op;
    dec_d.amt = fine ? 8'd1 : COARSE_STEP;
    if (code_in[31:16] != ADDRESS)        dec_d.err = 2'b01;
    else if (code_in[15:8] != ~code_in[7:0]) dec_d.err = 2'b10;
    else if (!known)                      dec_d.err = 2'b11;
    else                                  dec_d.err = 2'b00;
  end

  // Stage 2: 9-bit arithmetic so the carry/borrow bit drives saturation.
  for (genvar i = 0; i < 3; i++) begin : g_ch
    logic [8:0] sum, dif;
    assign sum = {1'b0, tgt[i]} + {1'b0, dec_q.amt};
    assign dif = {1'b0, tgt[i]} - {1'b0, dec_q.amt};
    assign stepped[i] = (dec_q.op == OP_SUB) ? (dif[8] ? 8'h00 : dif[7:0])
                                             : (sum[8] ? 8'hFF : sum[7:0]);
  end

  always_comb begin
    tgt_nxt = tgt;
    if (s1_vld && dec_q.err == 2'b00) begin
      case (dec_q.op)
        OP_CLR:  tgt_nxt = '0;
        OP_SET:  tgt_nxt = {3{8'hFF}};
        default: for (int i = 0; i < 3; i++)
                   if (dec_q.ch == 2'(i)) tgt_nxt[i] = stepped[i];
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s1_vld     <= 1'b0;
      dec_q      <= '0;
      tgt        <= {3{RESET_LEVEL}};
      cmd_ok_out <= 1'b0;
      err_out    <= 2'b00;
    end else begin
      s1_vld     <= new_code_in;
      if (new_code_in) dec_q <= dec_d;
      tgt        <= tgt_nxt;
      cmd_ok_out <= s1_vld && (dec_q.err == 2'b00);
      err_out    <= s1_vld ? dec_q.err : 2'b00;
    end
  end

`ifdef IR_FADE_EN
  localparam int CW = (RAMP_DIV > 2) ? $clog2(RAMP_DIV) : 1;
  logic [CW-1:0] ramp_cnt;
  logic          wrap;
  assign wrap = (ramp_cnt == CW'(RAMP_DIV - 1));

  // Counter never restarts on retarget, so fade cadence stays regular.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      ramp_cnt <= '0;
      lvl      <= {3{RESET_LEVEL}};
    end else begin
      ramp_cnt <= wrap ? '0 : ramp_cnt + CW'(1);
      if (wrap)
        for (int i = 0; i < 3; i++) begin
          if (lvl[i] < tgt[i])      lvl[i] <= lvl[i] + 8'd1;
          else if (lvl[i] > tgt[i]) lvl[i] <= lvl[i] - 8'd1;
        end
    end
  end

  assign busy_out = (lvl != tgt);
`else
  assign lvl      = tgt;
  assign busy_out = 1'b0;
`endif

  assign red_out   = lvl[0];
  assign green_out = lvl[1];
  assign blue_out  = lvl[2];

endmodule

// File: tb/tb_ir_rgb_command_unit.sv
// Scoreboard bench for ir_rgb_command_unit: directed frames with hand-computed results.
module tb_ir_rgb_command_unit;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] code_in;
  logic        new_code_in;
  logic [7:0]  red_out, green_out, blue_out;
  logic        cmd_ok_out;
  logic [1:0]  err_out;
  logic        busy_out;

  ir_rgb_command_unit #(.RAMP_DIV(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .code_in(code_in), .new_code_in(new_code_in),
    .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
    .cmd_ok_out(cmd_ok_out), .err_out(err_out), .busy_out(busy_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic       ok;
    logic [1:0] err;
    logic [7:0] r, g, b;
  } exp_t;

  typedef struct {
    logic [31:0] code;
    logic        b2b;
    logic [1:0]  err;
    logic [7:0]  r, g, b;
  } vec_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every cmd_ok/err pulse consumes one expected response.
  always @(negedge clk_in) begin
    if (!rst_in && (cmd_ok_out || err_out != 2'b00)) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got ok=%0b err=%0d expected no pulse", cmd_ok_out, err_out);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("cmd_ok", 32'(cmd_ok_out), 32'(e.ok));
        chk("err", 32'(err_out), 32'(e.err));
`ifndef IR_FADE_EN
        chk("red", 32'(red_out), 32'(e.r));
        chk("green", 32'(green_out), 32'(e.g));
        chk("blue", 32'(blue_out), 32'(e.b));
        chk("busy", 32'(busy_out), 32'd0);
`endif
      end
    end
  end

  // Drive one strobe cycle starting just after a rising edge.
  task automatic drive(input logic [31:0] code, input logic push, input exp_t e);
    code_in     = code;
    new_code_in = 1'b1;
    if (push) sbq.push_back(e);
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle(input int n);
    new_code_in = 1'b0;
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  vec_t vt[28];

  initial begin
    exp_t e;
    vt = '{
      '{32'h57E31EE1, 1'b0, 2'd0, 8'd6,   8'd1,   8'd1},
      '{32'h12341EE1, 1'b0, 2'd1, 8'd6,   8'd1,   8'd1},
      '{32'h57E31E00, 1'b0, 2'd2, 8'd6,   8'd1,   8'd1},
      '{32'h57E35AA5, 1'b0, 2'd3, 8'd6,   8'd1,   8'd1},
      '{32'h57E32DD2, 1'b0, 2'd0, 8'd5,   8'd1,   8'd1},
      '{32'h57E32DD2, 1'b0, 2'd0, 8'd4,   8'd1,   8'd1},
      '{32'h57E32DD2, 1'b0, 2'd0, 8'd3,   8'd1,   8'd1},
      '{32'h57E32CD3, 1'b0, 2'd0, 8'd0,   8'd1,   8'd1},
      '{32'h57E32CD3, 1'b0, 2'd0, 8'd0,   8'd1,   8'd1},
      '{32'h57E30DF2, 1'b0, 2'd0, 8'd255, 8'd255, 8'd255},
      '{32'h57E333CC, 1'b0, 2'd0, 8'd255, 8'd254, 8'd255},
      '{32'h57E333CC, 1'b0, 2'd0, 8'd255, 8'd253, 8'd255},
      '{32'h57E346B9, 1'b0, 2'd0, 8'd255, 8'd255, 8'd255},
      '{32'h57E31FE0, 1'b0, 2'd0, 8'd255, 8'd255, 8'd255},
      '{32'h57E30CF3, 1'b0, 2'd0, 8'd0,   8'd0,   8'd0},
      '{32'h57E38679, 1'b0, 2'd0, 8'd0,   8'd0,   8'd5},
      '{32'h57E38778, 1'b0, 2'd0, 8'd0,   8'd0,   8'd6},
      '{32'h57E3AA55, 1'b0, 2'd0, 8'd0,   8'd0,   8'd1},
      '{32'h57E3AB54, 1'b0, 2'd0, 8'd0,   8'd0,   8'd0},
      '{32'h57E347B8, 1'b0, 2'd0, 8'd0,   8'd1,   8'd0},
      '{32'h57E332CD, 1'b0, 2'd0, 8'd0,   8'd0,   8'd0},
      '{32'h57E31EE1, 1'b0, 2'd0, 8'd5,   8'd0,   8'd0},
      '{32'h57E31EE1, 1'b0, 2'd0, 8'd10,  8'd0,   8'd0},
      '{32'h57E31FE0, 1'b0, 2'd0, 8'd11,  8'd0,   8'd0},
      '{32'h57E31FE0, 1'b1, 2'd0, 8'd12,  8'd0,   8'd0},
      '{32'h57E32CD3, 1'b1, 2'd0, 8'd7,   8'd0,   8'd0},
      '{32'h57E31E00, 1'b1, 2'd2, 8'd7,   8'd0,   8'd0},
      '{32'h57E31FE0, 1'b1, 2'd0, 8'd8,   8'd0,   8'd0}
    };

    rst_in      = 1'b1;
    code_in     = '0;
    new_code_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #2 rst_in = 1'b0;
    repeat (2) @(negedge clk_in);
    chk("rst_red", 32'(red_out), 32'd1);
    chk("rst_green", 32'(green_out), 32'd1);
    chk("rst_blue", 32'(blue_out), 32'd1);
    chk("rst_ok", 32'(cmd_ok_out), 32'd0);
    chk("rst_err", 32'(err_out), 32'd0);
    chk("rst_busy", 32'(busy_out), 32'd0);
    @(posedge clk_in);
    #1;

    foreach (vt[i]) begin
      if (!vt[i].b2b) idle(3);
      e = '{ok: (vt[i].err == 2'd0), err: vt[i].err, r: vt[i].r, g: vt[i].g, b: vt[i].b};
      drive(vt[i].code, 1'b1, e);
    end
    idle(1);
    for (int k = 0; k < 20 && sbq.size() != 0; k++) @(posedge clk_in);
    chk("sb_drain", 32'(sbq.size()), 32'd0);

    // Async reset while a frame sits in the pipeline: no pulse, all levels back to 1.
    idle(2);
    e = '{ok: 1'b1, err: 2'd0, r: 8'd0, g: 8'd0, b: 8'd0};
    drive(32'h57E30DF2, 1'b0, e);
    new_code_in = 1'b0;
    #2 rst_in = 1'b1;
    #1;
    chk("midrst_red", 32'(red_out), 32'd1);
    chk("midrst_green", 32'(green_out), 32'd1);
    chk("midrst_blue", 32'(blue_out), 32'd1);
    chk("midrst_busy", 32'(busy_out), 32'd0);
    repeat (2) @(posedge clk_in);
    #2 rst_in = 1'b0;
    repeat (5) @(posedge clk_in);
    #1;
    chk("midrst_hold", 32'({red_out, green_out, blue_out}), 32'h010101);

`ifdef IR_FADE_EN
    begin
      logic [7:0] prev;
      int last_chg, cyc;
      e = '{ok: 1'b1, err: 2'd0, r: 8'd255, g: 8'd255, b: 8'd255};
      drive(32'h57E30DF2, 1'b1, e);
      idle(40);
      #2 rst_in = 1'b1;
      #1;
      chk("fade_rst_red", 32'(red_out), 32'd1);
      chk("fade_rst_blue", 32'(blue_out), 32'd1);
      chk("fade_rst_busy", 32'(busy_out), 32'd0);
      repeat (2) @(posedge clk_in);
      #2 rst_in = 1'b0;
      @(posedge clk_in);
      #1;
      drive(32'h57E30DF2, 1'b1, e);
      new_code_in = 1'b0;
      prev = 8'd1;
      last_chg = -1;
      for (cyc = 0; cyc < 1200; cyc++) begin
        @(negedge clk_in);
        if (red_out != prev) begin
          chk("fade_step", 32'(red_out), 32'(prev + 8'd1));
          if (last_chg >= 0) chk("fade_interval", 32'(cyc - last_chg), 32'd4);
          last_chg = cyc;
          prev = red_out;
        end
        if (last_chg >= 0 && red_out != 8'd255)
          chk("fade_busy_hi", 32'(busy_out), 32'd1);
        if (red_out == 8'd255 && green_out == 8'd255 && blue_out == 8'd255) break;
      end
      chk("fade_done", 32'({red_out, green_out, blue_out}), 32'hFFFFFF);
      @(negedge clk_in);
      chk("fade_busy_lo", 32'(busy_out), 32'd0);
    end
`endif

    chk("sb_final", 32'(sbq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
